// File: rtl/sound_in_scheduler.sv
// Microphone record sequencing and packet-transmitter arbitration for the monitor link.
// Sound-in words have priority over keyboard events. A keyboard event is still guaranteed a slot
// after MIC_BURST back-to-back mic packets.
module sound_in_scheduler #(
    parameter logic [7:0]  CMD_REC_START = 8'h07,
    parameter logic [7:0]  CMD_REC_STOP  = 8'h06,
    parameter logic [7:0]  HDR_SOUNDIN   = 8'hC7,
    parameter logic [7:0]  HDR_KBD       = 8'hC5,
    parameter int unsigned MIC_BURST     = 3,
    parameter int unsigned MIC_TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_data,
    output logic        record_start,
    output logic        record_stop,
    input  logic [31:0] mic_data,
    input  logic        mic_data_valid,
    output logic        mic_data_retrieved,
    input  logic        kbd_valid,
    input  logic [15:0] kbd_data,
    output logic        kbd_ack,
    input  logic        tx_ready,
    output logic        tx_start,
    output logic [39:0] tx_data,
    output logic        recording,
    output logic        mic_overrun,
    output logic [15:0] mic_packet_count
);

    localparam int unsigned SW = $clog2(MIC_BURST + 1);
    localparam logic [SW-1:0] BURST_MAX = SW'(MIC_BURST);
    localparam logic [7:0] TMO_MAX = 8'(MIC_TIMEOUT);

    typedef enum logic [1:0] {StIdle, StSend, StBusy} state_e;

    state_e        state;
    logic [SW-1:0] starv;
    logic [7:0]    tmo;
    logic [7:0]    tmo_next;
    logic          seen_low;

    logic start_cmd, stop_cmd, mic_req, kbd_req, arb, kbd_wins, mic_grant, kbd_grant;

    // Command decode and arbitration; a stop in the arbitration cycle suppresses the mic grant.
    always_comb begin
        start_cmd = cmd_valid && (cmd_data == CMD_REC_START) && !recording;
        stop_cmd  = cmd_valid && (cmd_data == CMD_REC_STOP) && recording;
        mic_req   = mic_data_valid && recording && !stop_cmd;
        kbd_req   = kbd_valid;
        arb       = (state == StIdle) && tx_ready;
        kbd_wins  = kbd_req && (!mic_req || (starv == BURST_MAX));
        mic_grant = arb && mic_req && !kbd_wins;
        kbd_grant = arb && kbd_wins;
        tmo_next  = 8'h00;
        if (mic_req && !mic_grant) begin
            tmo_next = (tmo == 8'hFF) ? tmo : tmo + 8'h01;
        end
    end

    // Registered state, pulses and transmit FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= StIdle;
            seen_low           <= 1'b0;
            starv              <= '0;
            tmo                <= 8'h00;
            record_start       <= 1'b0;
            record_stop        <= 1'b0;
            mic_data_retrieved <= 1'b0;
            kbd_ack            <= 1'b0;
            tx_start           <= 1'b0;
            tx_data            <= 40'h0;
            recording          <= 1'b0;
            mic_overrun        <= 1'b0;
            mic_packet_count   <= 16'h0;
        end else begin
            record_start       <= start_cmd;
            record_stop        <= stop_cmd;
            mic_data_retrieved <= mic_grant;
            kbd_ack            <= kbd_grant;
            tx_start           <= 1'b0;
            tmo                <= tmo_next;

            if (start_cmd) begin
                recording <= 1'b1;
            end else if (stop_cmd) begin
                recording <= 1'b0;
            end

            if (start_cmd) begin
                mic_overrun <= 1'b0;
            end else if (mic_req && !mic_grant && (tmo_next == TMO_MAX)) begin
                mic_overrun <= 1'b1;
            end

            if (start_cmd) begin
                mic_packet_count <= 16'h0;
            end else if (mic_grant) begin
                mic_packet_count <= mic_packet_count + 16'h1;
            end

            if (kbd_grant) begin
                starv <= '0;
            end else if (mic_grant) begin
                if (!kbd_req) begin
                    starv <= '0;
                end else if (starv != BURST_MAX) begin
                    starv <= starv + 1'b1;
                end
            end

            unique case (state)
                StIdle: begin
                    if (mic_grant) begin
                        tx_data <= {HDR_SOUNDIN, mic_data};
                        state   <= StSend;
                    end else if (kbd_grant) begin
                        tx_data <= {HDR_KBD, kbd_data, 16'h0000};
                        state   <= StSend;
                    end
                end
                StSend: begin
                    tx_start <= 1'b1;
                    seen_low <= 1'b0;
                    state    <= StBusy;
                end
                StBusy: begin
                    // Leave only after a full low-then-high handshake from the transmitter.
                    if (!tx_ready) begin
                        seen_low <= 1'b1;
                    end else if (seen_low) begin
                        seen_low <= 1'b0;
                        state    <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
